// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: bus window, register offsets,
// FSM state encodings and the "no interrupt" id.
package irq_ctrl_pkg;

  localparam logic [31:0] DEV2ADDR_BEGIN = 32'h0000_7F80;
  localparam logic [31:0] DEV2ADDR_END   = 32'h0000_7F9F;

  localparam logic [4:0] IRQ_CTRL_OFS_CTRL    = 5'h00;
  localparam logic [4:0] IRQ_CTRL_OFS_MASK    = 5'h04;
  localparam logic [4:0] IRQ_CTRL_OFS_MODE    = 5'h08;
  localparam logic [4:0] IRQ_CTRL_OFS_PENDING = 5'h0C;
  localparam logic [4:0] IRQ_CTRL_OFS_CLAIM   = 5'h10;
  localparam logic [4:0] IRQ_CTRL_OFS_RAW     = 5'h14;

  localparam logic [1:0] IRQ_IDLE = 2'd0;
  localparam logic [1:0] IRQ_REQ  = 2'd1;
  localparam logic [1:0] IRQ_SVC  = 2'd2;

  localparam logic [2:0] IRQ_ID_NONE = 3'd7;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; id is IRQ_ID_NONE when nothing is requesting.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NIRQ = 6
) (
  input  logic [NIRQ-1:0] req,
  output logic            valid,
  output logic [2:0]      id
);

  always_comb begin
    valid = 1'b0;
    id    = IRQ_ID_NONE;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped, non-nested interrupt controller with one ack-handshaked request to CP0.
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser ahead of the sample register.
//
//   state    | meaning
//   IRQ_IDLE | nothing outstanding, waiting for an eligible pending line
//   IRQ_REQ  | int_req high, waiting for int_ack (falls back if eligibility vanishes)
//   IRQ_SVC  | line claimed, int_id valid, waiting for an EOI write to CLAIM
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] base = DEV2ADDR_BEGIN,
  parameter int          NIRQ = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     RD,
  input  logic [NIRQ-1:0] irq_in,
  output logic            int_req,
  input  logic            int_ack,
  output logic [2:0]      int_id
);

  logic [31:0]     offset;
  logic            sel;
  logic [4:0]      rsel;
  logic            wr_ctrl, wr_mask, wr_mode, wr_pend, wr_claim;

  logic            ge;
  logic [NIRQ-1:0] mask, mode, pending, pending_d;
  logic [NIRQ-1:0] samp, samp_d, prev;
  logic [NIRQ-1:0] eligible, edge_set, w1c, claim_clr;
  logic            elig_valid;
  logic [2:0]      top_id;
  logic [1:0]      state, state_d;
  logic [2:0]      id_d;
  logic            unused_wd;

  assign unused_wd = ^wd[31:NIRQ];

  assign offset   = Addr - base;
  assign sel      = (offset[31:5] == 27'd0);
  assign rsel     = offset[4:0];
  assign wr_ctrl  = we & sel & (rsel == IRQ_CTRL_OFS_CTRL);
  assign wr_mask  = we & sel & (rsel == IRQ_CTRL_OFS_MASK);
  assign wr_mode  = we & sel & (rsel == IRQ_CTRL_OFS_MODE);
  assign wr_pend  = we & sel & (rsel == IRQ_CTRL_OFS_PENDING);
  assign wr_claim = we & sel & (rsel == IRQ_CTRL_OFS_CLAIM);

`ifdef IRQ_CTRL_SYNC_EN
  logic [NIRQ-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign samp_d = sync2;
`else
  assign samp_d = irq_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp <= '0;
      prev <= '0;
    end else begin
      samp <= samp_d;
      prev <= samp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ge   <= 1'b0;
      mask <= '0;
      mode <= '0;
    end else begin
      if (wr_ctrl) ge <= wd[0];
      if (wr_mask) mask <= wd[NIRQ-1:0];
      if (wr_mode) mode <= wd[NIRQ-1:0];
    end
  end

  assign eligible = pending & mask & {NIRQ{ge}};

  irq_prio_enc #(.NIRQ(NIRQ)) u_prio_enc (
    .req   (eligible),
    .valid (elig_valid),
    .id    (top_id)
  );

  // A fresh edge in the same cycle beats both W1C and the claim clear.
  always_comb begin
    edge_set  = samp & ~prev;
    w1c       = wr_pend ? wd[NIRQ-1:0] : '0;
    claim_clr = '0;
    if ((state == IRQ_REQ) && int_ack && elig_valid)
      claim_clr = mode & (NIRQ'(1) << top_id);
    pending_d = (mode & (edge_set | (pending & ~w1c & ~claim_clr))) | (~mode & samp);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_d;
  end

  always_comb begin
    state_d = state;
    id_d    = int_id;
    case (state)
      IRQ_IDLE: begin
        if (elig_valid) state_d = IRQ_REQ;
      end
      IRQ_REQ: begin
        if (!elig_valid) begin
          state_d = IRQ_IDLE;
        end else if (int_ack) begin
          state_d = IRQ_SVC;
          id_d    = top_id;
        end
      end
      IRQ_SVC: begin
        if (wr_claim) begin
          state_d = IRQ_IDLE;
          id_d    = IRQ_ID_NONE;
        end
      end
      default: begin
        state_d = IRQ_IDLE;
        id_d    = IRQ_ID_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IRQ_IDLE;
      int_req <= 1'b0;
      int_id  <= IRQ_ID_NONE;
    end else begin
      state   <= state_d;
      int_req <= (state_d == IRQ_REQ);
      int_id  <= id_d;
    end
  end

  always_comb begin
    RD = '0;
    if (sel) begin
      case (rsel)
        IRQ_CTRL_OFS_CTRL:    RD = {31'd0, ge};
        IRQ_CTRL_OFS_MASK:    RD = {{(32-NIRQ){1'b0}}, mask};
        IRQ_CTRL_OFS_MODE:    RD = {{(32-NIRQ){1'b0}}, mode};
        IRQ_CTRL_OFS_PENDING: RD = {{(32-NIRQ){1'b0}}, pending};
        IRQ_CTRL_OFS_CLAIM:   RD = {29'd0, int_id};
        IRQ_CTRL_OFS_RAW:     RD = {{(32-NIRQ){1'b0}}, samp};
        default:              RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/100ps
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int          NIRQ = 6;
  localparam logic [31:0] BASE = 32'h0000_7F80;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     Addr = BASE;
  logic            we = 1'b0;
  logic [31:0]     wd = '0;
  logic [31:0]     RD;
  logic [NIRQ-1:0] irq_in = '0;
  logic            int_req;
  logic            int_ack = 1'b0;
  logic [2:0]      int_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.base(BASE), .NIRQ(NIRQ)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .we      (we),
    .wd      (wd),
    .RD      (RD),
    .irq_in  (irq_in),
    .int_req (int_req),
    .int_ack (int_ack),
    .int_id  (int_id)
  );

  // Behavioural model: boolean "requesting"/"in service" flags, claimed id,
  // register images and a delay line for the input sampling.
  logic [NIRQ-1:0] m_d0, m_d1, m_s, m_prev, m_pend, m_mask, m_mode;
  logic            m_ge, m_req, m_svc;
  logic [2:0]      m_id;

  always @(posedge clk or posedge reset) begin
    logic [31:0]     off;
    logic            hit;
    logic [4:0]      r;
    logic [NIRQ-1:0] elig, clr, w1c, np, stage;
    int              first;
    if (reset) begin
      m_d0 = '0; m_d1 = '0; m_s = '0; m_prev = '0; m_pend = '0;
      m_mask = '0; m_mode = '0; m_ge = 1'b0; m_req = 1'b0; m_svc = 1'b0;
      m_id = 3'd7;
    end else begin
      off   = Addr - BASE;
      hit   = (off < 32);
      r     = off[4:0];
      elig  = m_pend & m_mask & (m_ge ? {NIRQ{1'b1}} : {NIRQ{1'b0}});
      first = -1;
      for (int i = 0; i < NIRQ; i++) if (elig[i] && first < 0) first = i;
      clr = '0;
      if (m_svc) begin
        if (we && hit && r == 5'h10) begin m_svc = 1'b0; m_id = 3'd7; end
      end else if (m_req) begin
        if (first < 0) m_req = 1'b0;
        else if (int_ack) begin
          m_req = 1'b0; m_svc = 1'b1; m_id = 3'(first);
          if (m_mode[first]) clr[first] = 1'b1;
        end
      end else if (first >= 0) begin
        m_req = 1'b1;
      end
      w1c = (we && hit && r == 5'h0C) ? wd[NIRQ-1:0] : '0;
      for (int i = 0; i < NIRQ; i++) begin
        if (!m_mode[i])                 np[i] = m_s[i];
        else if (m_s[i] && !m_prev[i])  np[i] = 1'b1;
        else if (w1c[i] || clr[i])      np[i] = 1'b0;
        else                            np[i] = m_pend[i];
      end
      m_pend = np;
      if (we && hit && r == 5'h00) m_ge = wd[0];
      if (we && hit && r == 5'h04) m_mask = wd[NIRQ-1:0];
      if (we && hit && r == 5'h08) m_mode = wd[NIRQ-1:0];
      stage  = (SYNC_LAT == 2) ? m_d1 : irq_in;
      m_d1   = m_d0;
      m_d0   = irq_in;
      m_prev = m_s;
      m_s    = stage;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32) return 32'd0;
    case (off[4:0])
      5'h00:   return {31'd0, m_ge};
      5'h04:   return 32'(m_mask);
      5'h08:   return 32'(m_mode);
      5'h0C:   return 32'(m_pend);
      5'h10:   return 32'(m_id);
      5'h14:   return 32'(m_s);
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    checks++;
    if (int_req !== m_req) begin
      failures++;
      if (failures <= 30) $display("FAIL model_int_req t=%0t got=%b exp=%b", $time, int_req, m_req);
    end
    checks++;
    if (int_id !== m_id) begin
      failures++;
      if (failures <= 30) $display("FAIL model_int_id t=%0t got=%0d exp=%0d", $time, int_id, m_id);
    end
    checks++;
    if (RD !== exp_rd(Addr)) begin
      failures++;
      if (failures <= 30) $display("FAIL model_rd t=%0t addr=%h got=%h exp=%h", $time, Addr, RD, exp_rd(Addr));
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] ofs, input logic [31:0] d);
    Addr = BASE + 32'(ofs);
    wd   = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    wd   = '0;
  endtask

  task automatic rdc(input string nm, input logic [4:0] ofs, input logic [31:0] exp);
    Addr = BASE + 32'(ofs);
    #1;
    chk(nm, RD, exp);
  endtask

  task automatic sampled();
    tick();
    repeat (SYNC_LAT) tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick();

    rdc("rst_ctrl", 5'h00, 32'h0);
    rdc("rst_mask", 5'h04, 32'h0);
    rdc("rst_mode", 5'h08, 32'h0);
    rdc("rst_pend", 5'h0C, 32'h0);
    rdc("rst_claim", 5'h10, 32'h7);
    rdc("rst_raw", 5'h14, 32'h0);
    chk("rst_int_req", {31'd0, int_req}, 32'h0);

    // Edge line 0: pulse, claim, EOI
    wr(5'h04, 32'h3);
    wr(5'h08, 32'h1);
    wr(5'h00, 32'h1);
    irq_in[0] = 1'b1;
    sampled();
    irq_in[0] = 1'b0;
    tick();
    rdc("edge_pend_set", 5'h0C, 32'h1);
    chk("edge_req_not_yet", {31'd0, int_req}, 32'h0);
    tick();
    chk("edge_req_up", {31'd0, int_req}, 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("edge_claim_id", {29'd0, int_id}, 32'h0);
    chk("edge_claim_req", {31'd0, int_req}, 32'h0);
    rdc("edge_pend_clr", 5'h0C, 32'h0);
    wr(5'h10, 32'h0);
    chk("edge_eoi_id", {29'd0, int_id}, 32'h7);

    // Level line 1 drops before ack
    irq_in[1] = 1'b1;
    sampled();
    tick();
    rdc("lvl_pend", 5'h0C, 32'h2);
    tick();
    chk("lvl_req_up", {31'd0, int_req}, 32'h1);
    irq_in[1] = 1'b0;
    sampled();
    tick();
    chk("lvl_req_hold", {31'd0, int_req}, 32'h1);
    tick();
    chk("lvl_req_drop", {31'd0, int_req}, 32'h0);
    rdc("lvl_claim_none", 5'h10, 32'h7);

    // Two edge lines at once: id 0 then id 1
    wr(5'h08, 32'h3);
    irq_in = 6'b000011;
    sampled();
    irq_in = '0;
    tick();
    rdc("two_pend", 5'h0C, 32'h3);
    tick();
    chk("two_req_up", {31'd0, int_req}, 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("two_first_id", {29'd0, int_id}, 32'h0);
    rdc("two_pend_after", 5'h0C, 32'h2);
    tick();
    tick();
    chk("two_svc_no_req", {31'd0, int_req}, 32'h0);
    rdc("two_svc_pend", 5'h0C, 32'h2);
    wr(5'h10, 32'h0);
    chk("two_eoi_id", {29'd0, int_id}, 32'h7);
    tick();
    chk("two_req_again", {31'd0, int_req}, 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("two_second_id", {29'd0, int_id}, 32'h1);
    rdc("two_pend_empty", 5'h0C, 32'h0);
    wr(5'h10, 32'h0);

    // Set beats W1C; GE=0 blocks requests
    wr(5'h00, 32'h0);
    irq_in[0] = 1'b1;
    sampled();
    irq_in[0] = 1'b0;
    wr(5'h0C, 32'h1);
    rdc("w1c_set_wins", 5'h0C, 32'h1);
    repeat (3) tick();
    chk("ge_off_no_req", {31'd0, int_req}, 32'h0);
    wr(5'h0C, 32'h1);
    rdc("w1c_clears", 5'h0C, 32'h0);

    // Async reset mid-service
    wr(5'h00, 32'h1);
    irq_in[0] = 1'b1;
    sampled();
    irq_in[0] = 1'b0;
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("svc_before_rst", {29'd0, int_id}, 32'h0);
    #1 reset = 1'b1;
    #0.5;
    chk("arst_int_req", {31'd0, int_req}, 32'h0);
    chk("arst_int_id", {29'd0, int_id}, 32'h7);
    rdc("arst_ctrl", 5'h00, 32'h0);
    rdc("arst_mask", 5'h04, 32'h0);
    rdc("arst_mode", 5'h08, 32'h0);
    rdc("arst_pend", 5'h0C, 32'h0);
    rdc("arst_claim", 5'h10, 32'h7);
    rdc("arst_raw", 5'h14, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();

    // Randomized traffic, checked by the model every cycle
    wr(5'h04, 32'h3F);
    wr(5'h08, 32'h2A);
    wr(5'h00, 32'h1);
    for (int n = 0; n < 4000; n++) begin
      logic [4:0] ofs;
      for (int b = 0; b < NIRQ; b++)
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      ofs = 5'($urandom_range(0, 7) * 4);
      case ($urandom_range(0, 15))
        0:       Addr = BASE + 32'h40;
        1:       Addr = BASE - 32'h4;
        2:       Addr = BASE + 32'($urandom_range(0, 31));
        default: Addr = BASE + 32'(ofs);
      endcase
      we = ($urandom_range(0, 3) == 0);
      if (Addr == BASE) wd = ($urandom_range(0, 7) != 0) ? 32'h1 : $urandom;
      else              wd = $urandom;
      if (int_req) int_ack = ($urandom_range(0, 1) == 1);
      else         int_ack = ($urandom_range(0, 15) == 0);
      tick();
    end
    we = 1'b0;
    int_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
